commit_nway: RTL and testbench

COMMIT_NWAY -- requirements
Module: commit_nway

---
 rtl/commit_nway.sv | 139 +++++++++++++
 tb/tb_commit_nway.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_nway.sv
// N-way result commit: per-channel FIFOs, round-robin arbiter, one regfile write per cycle.
// Define COMMIT_BYPASS_EN to let empty channels forward a beat straight to the write port.
module commit_nway #(
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int RN_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*RN_W-1:0]   ch_rn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_stall,
    input  logic                     flush,
    output logic [RN_W-1:0]          write_rn,
    output logic [DATA_W-1:0]        write_data,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH);

    logic [PW:0]        wr_ptr_q   [NUM_CH];
    logic [PW:0]        wr_ptr_d   [NUM_CH];
    logic [PW:0]        rd_ptr_q   [NUM_CH];
    logic [PW:0]        rd_ptr_d   [NUM_CH];
    logic [RN_W-1:0]    mem_rn_q   [NUM_CH][DEPTH];
    logic [RN_W-1:0]    mem_rn_d   [NUM_CH][DEPTH];
    logic [DATA_W-1:0]  mem_data_q [NUM_CH][DEPTH];
    logic [DATA_W-1:0]  mem_data_d [NUM_CH][DEPTH];
    logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [RN_W-1:0]    write_rn_q, write_rn_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;

    logic [RN_W-1:0]    in_rn   [NUM_CH];
    logic [DATA_W-1:0]  in_data [NUM_CH];
    logic [NUM_CH-1:0]  empty, full, push, push_eff, pop, cand, grant_oh;
    logic               grant_vld;
    logic [CW-1:0]      grant_idx;
    logic [RN_W-1:0]    head_rn;
    logic [DATA_W-1:0]  head_data;

    // Full/empty come only from pointer flops, so a same-cycle pop never lifts a stall.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_rn[i]   = ch_rn[i*RN_W +: RN_W];
            in_data[i] = ch_data[i*DATA_W +: DATA_W];
            empty[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]    = (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]) &&
                         (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]);
            push[i]    = ch_valid[i] && !full[i] && (in_rn[i] != '0) && !flush;
        end
    end

    always_comb begin : arb
        int j;
        j         = 0;
        cand      = ~empty;
`ifdef COMMIT_BYPASS_EN
        cand      = cand | (empty & push);
`endif
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!grant_vld && cand[j]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(j);
            end
        end
        if (flush) grant_vld = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == CW'(i));
            pop[i]      = grant_oh[i] && !empty[i];
            push_eff[i] = push[i] && !(grant_oh[i] && empty[i]);
        end
        head_rn   = mem_rn_q[grant_idx][rd_ptr_q[grant_idx][PW-1:0]];
        head_data = mem_data_q[grant_idx][rd_ptr_q[grant_idx][PW-1:0]];
`ifdef COMMIT_BYPASS_EN
        if (empty[grant_idx]) begin
            head_rn   = in_rn[grant_idx];
            head_data = in_data[grant_idx];
        end
`endif
    end

    always_comb begin
        mem_rn_d   = mem_rn_q;
        mem_data_d = mem_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + {{PW{1'b0}}, push_eff[i]};
            rd_ptr_d[i] = rd_ptr_q[i] + {{PW{1'b0}}, pop[i]};
            if (push_eff[i]) begin
                mem_rn_d[i][wr_ptr_q[i][PW-1:0]]   = in_rn[i];
                mem_data_d[i][wr_ptr_q[i][PW-1:0]] = in_data[i];
            end
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end
        end
        write_rn_d   = grant_vld ? head_rn : '0;
        write_data_d = grant_vld ? head_data : write_data_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_vld)
            rr_ptr_d = (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + CW'(1);
        if (flush) rr_ptr_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            mem_rn_q     <= '{default: '{default: '0}};
            mem_data_q   <= '{default: '{default: '0}};
            rr_ptr_q     <= '0;
            write_rn_q   <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_rn_q     <= mem_rn_d;
            mem_data_q   <= mem_data_d;
            rr_ptr_q     <= rr_ptr_d;
            write_rn_q   <= write_rn_d;
            write_data_q <= write_data_d;
        end
    end

    assign ch_stall   = full;
    assign write_rn   = write_rn_q;
    assign write_data = write_data_q;
    assign busy       = (|(~empty)) || (write_rn_q != '0);

endmodule

// File: tb/tb_commit_nway.sv
// Self-checking bench for commit_nway (default build): single-beat table,
// round-robin, back-pressure, rn-zero, flush and mid-operation reset.
module tb_commit_nway;

    localparam int NC = 5;
    localparam int DW = 64;
    localparam int RW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     ch_valid;
    logic [NC*RW-1:0]  ch_rn;
    logic [NC*DW-1:0]  ch_data;
    logic [NC-1:0]     ch_stall;
    logic              flush;
    logic [RW-1:0]     write_rn;
    logic [DW-1:0]     write_data;
    logic              busy;

    commit_nway dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_valid   (ch_valid),
        .ch_rn      (ch_rn),
        .ch_data    (ch_data),
        .ch_stall   (ch_stall),
        .flush      (flush),
        .write_rn   (write_rn),
        .write_data (write_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            ch;
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
        logic [RW-1:0] exp_rn;
        logic          exp_busy;
    } vec_t;

    beat_t exp_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; afterwards every nonzero commit is matched against the scoreboard.
    task automatic step();
        beat_t b;
        @(posedge clk);
        #1;
        if (rst_n && write_rn != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 64'(write_rn), 64'd0);
            end else begin
                b = exp_q.pop_front();
                chk("commit_rn", 64'(write_rn), 64'(b.rn));
                chk("commit_data", write_data, b.data);
            end
        end
    endtask

    task automatic drive(input int ch, input logic [RW-1:0] rn, input logic [DW-1:0] data,
                         input bit expect_commit);
        beat_t b;
        ch_valid[ch]         = 1'b1;
        ch_rn[ch*RW +: RW]   = rn;
        ch_data[ch*DW +: DW] = data;
        if (expect_commit) begin
            b.rn   = rn;
            b.data = data;
            exp_q.push_back(b);
        end
    endtask

    task automatic idle_in();
        ch_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    vec_t       tbl[5];
    logic [5:0] bp_seq[3];
    int         bp_idx;
    int         cyc;
    bit         acc;

    initial begin
        tbl[0] = '{ch: 2, rn: 6'd5,  data: 64'hDEAD,             exp_rn: 6'd5,  exp_busy: 1'b1};
        tbl[1] = '{ch: 3, rn: 6'd0,  data: 64'h1234,             exp_rn: 6'd0,  exp_busy: 1'b0};
        tbl[2] = '{ch: 0, rn: 6'd63, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_rn: 6'd63, exp_busy: 1'b1};
        tbl[3] = '{ch: 4, rn: 6'd1,  data: 64'h0,                exp_rn: 6'd1,  exp_busy: 1'b1};
        tbl[4] = '{ch: 1, rn: 6'd0,  data: 64'h55,               exp_rn: 6'd0,  exp_busy: 1'b0};
        bp_seq[0] = 6'd7;
        bp_seq[1] = 6'd8;
        bp_seq[2] = 6'd9;

        rst_n    = 1'b0;
        ch_valid = '0;
        ch_rn    = '0;
        ch_data  = '0;
        flush    = 1'b0;
        #3;
        chk("rst_write_rn", 64'(write_rn), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(ch_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single beats: two-edge latency, rn zero dropped, busy falls the next cycle.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].ch, tbl[i].rn, tbl[i].data, tbl[i].exp_rn != '0);
            step();
            idle_in();
            chk("vec_edge0_rn", 64'(write_rn), 64'd0);
            chk("vec_edge0_busy", 64'(busy), 64'(tbl[i].exp_busy));
            step();
            chk("vec_edge1_rn", 64'(write_rn), 64'(tbl[i].exp_rn));
            if (tbl[i].exp_rn != '0) chk("vec_edge1_data", write_data, tbl[i].data);
            chk("vec_edge1_busy", 64'(busy), 64'(tbl[i].exp_busy));
            step();
            chk("vec_edge2_rn", 64'(write_rn), 64'd0);
            chk("vec_edge2_busy", 64'(busy), 64'd0);
        end

        // Flush with four entries buffered plus a push in the flush cycle.
        for (int c = 0; c < 4; c++) drive(c, 6'(31 + c), 64'(c), 1'b0);
        step();
        idle_in();
        chk("flush_pre_busy", 64'(busy), 64'd1);
        drive(4, 6'd40, 64'h40, 1'b0);
        flush = 1'b1;
        step();
        idle_in();
        chk("flush_write_rn", 64'(write_rn), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_stall", 64'(ch_stall), 64'd0);
        repeat (4) step();
        chk("flush_still_idle", 64'(busy), 64'd0);

        // Round-robin from rr_ptr=0 (left there by the flush).
        for (int c = 0; c < NC; c++) drive(c, 6'(c + 1), 64'(16'hA0 + c), 1'b1);
        step();
        idle_in();
        repeat (5) step();
        chk("rr0_drained", 64'(exp_q.size()), 64'd0);

        // Commit one beat on ch2 so rr_ptr becomes 3, then repeat.
        drive(2, 6'd9, 64'h99, 1'b1);
        step();
        idle_in();
        step();
        for (int c = 3; c < NC; c++) drive(c, 6'(c + 1), 64'(16'hB0 + c), 1'b1);
        for (int c = 0; c < 3; c++) drive(c, 6'(c + 1), 64'(16'hB0 + c), 1'b1);
        step();
        idle_in();
        repeat (5) step();
        chk("rr3_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: rr_ptr=1, ch0 pushes 7,8,9 while ch1..4 fill up.
        do_flush();
        drive(0, 6'd1, 64'h11, 1'b1);
        step();
        idle_in();
        step();
        for (int c = 1; c < NC; c++) exp_q.push_back('{rn: 6'(10 + c), data: 64'(16'h1000 + 10 + c)});
        exp_q.push_back('{rn: 6'd7, data: 64'h1007});
        for (int c = 1; c < NC; c++) exp_q.push_back('{rn: 6'(20 + c), data: 64'(16'h1000 + 20 + c)});
        exp_q.push_back('{rn: 6'd8, data: 64'h1008});
        exp_q.push_back('{rn: 6'd9, data: 64'h1009});
        bp_idx = 0;
        cyc    = 0;
        while (bp_idx < 3 && cyc < 20) begin
            idle_in();
            drive(0, bp_seq[bp_idx], 64'(16'h1000) + 64'(bp_seq[bp_idx]), 1'b0);
            if (cyc < 2)
                for (int c = 1; c < NC; c++)
                    drive(c, 6'(10 * (cyc + 1) + c), 64'(16'h1000 + 10 * (cyc + 1) + c), 1'b0);
            if (cyc == 2) chk("bp_stall_third", 64'(ch_stall[0]), 64'd1);
            acc = !ch_stall[0];
            step();
            if (acc) bp_idx++;
            cyc++;
        end
        idle_in();
        chk("bp_all_accepted", 64'(bp_idx), 64'd3);
        for (int t = 0; t < 30 && busy; t++) step();
        chk("bp_drained_busy", 64'(busy), 64'd0);
        chk("bp_drained_queue", 64'(exp_q.size()), 64'd0);

        // Reset with three entries still buffered.
        do_flush();
        for (int c = 0; c < 4; c++) drive(c, 6'(41 + c), 64'(16'h4100 + c), c == 0);
        step();
        idle_in();
        step();
        chk("rstmid_first_commit", 64'(exp_q.size()), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_write_rn", 64'(write_rn), 64'd0);
        chk("rstmid_write_data", write_data, 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        step();
        #2;
        rst_n = 1'b1;
        repeat (4) step();
        chk("rstmid_idle_busy", 64'(busy), 64'd0);
        drive(3, 6'd50, 64'h5050, 1'b1);
        step();
        idle_in();
        chk("rstmid_fresh_edge0", 64'(write_rn), 64'd0);
        step();
        chk("rstmid_fresh_edge1", 64'(write_rn), 64'd50);
        step();
        chk("rstmid_fresh_busy", 64'(busy), 64'd0);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
